// File: rtl/bsg_decode_pkg.sv
// bsg_decode_pkg: shared types and constants for the decode pipe (buffer states, decode modes, err counter width)
package bsg_decode_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  typedef enum logic {ONEHOT, THERM} mode_e;
  localparam int err_cnt_width_lp = 8;
endpackage

// File: rtl/bsg_decode_core.sv
// bsg_decode_core: combinational one-hot/thermometer decode of i (mode_i) into o; err_o flags i >= num_out_p and forces o to zero
module bsg_decode_core
  import bsg_decode_pkg::*;
#(
  parameter int num_out_p = 32,
  localparam int lg_num_out_lp = $clog2(num_out_p)
) (
  input  logic [lg_num_out_lp-1:0] i,
  input  logic                     mode_i,
  output logic [num_out_p-1:0]     o,
  output logic                     err_o
);
  logic [num_out_p-1:0] ones, onehot, therm;
  assign ones = '1;
  assign err_o = {1'b0, i} >= (lg_num_out_lp+1)'(num_out_p);
  assign onehot = {{(num_out_p-1){1'b0}}, 1'b1} << i;
  // two shifts so i = num_out_p-1 clears every bit without an overwide shift amount
  assign therm = ~((ones << i) << 1);
  assign o = err_o ? '0 : (mode_e'(mode_i) == THERM ? therm : onehot);
endmodule

// File: rtl/bsg_decode_pipe.sv
// bsg_decode_pipe: latency-1 decoder with 2-entry main+skid buffer, valid/ready in, valid/yumi out, async active-low reset_n_i; BSG_DECODE_PIPE_ERR_CNT_EN enables the saturating err_cnt_o
module bsg_decode_pipe
  import bsg_decode_pkg::*;
#(
  parameter int num_out_p = 32,
  localparam int lg_num_out_lp = $clog2(num_out_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        v_i,
  input  logic [lg_num_out_lp-1:0]    i,
  input  logic                        mode_i,
  output logic                        ready_o,
  output logic                        v_o,
  output logic [num_out_p-1:0]        o,
  output logic                        err_o,
  input  logic                        yumi_i,
  output logic [err_cnt_width_lp-1:0] err_cnt_o
);
  state_e state_r, state_n;
  logic [num_out_p-1:0] dec_o, skid_o;
  logic dec_err, skid_err, acc, deq, load_main, load_skid, shift;
  bsg_decode_core #(.num_out_p(num_out_p)) core (.i(i), .mode_i(mode_i), .o(dec_o), .err_o(dec_err));
  assign v_o = state_r != EMPTY;
  assign acc = v_i & ready_o;
  assign deq = yumi_i & v_o;
  always_comb begin
    state_n = state_r == EMPTY ? (acc ? ONE : EMPTY)
            : state_r == ONE ? (acc == deq ? ONE : (acc ? TWO : EMPTY))
            : (deq ? ONE : TWO);
    load_main = acc & (state_r == EMPTY | (state_r == ONE & deq));
    load_skid = acc & state_r == ONE & ~deq;
    shift = deq & state_r == TWO;
  end
  // ready_o is registered from the next state so it never depends combinationally on v_i/yumi_i
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= EMPTY;
      ready_o <= 1'b0;
      o <= '0;
      err_o <= 1'b0;
      skid_o <= '0;
      skid_err <= 1'b0;
    end else begin
      state_r <= state_n;
      ready_o <= state_n != TWO;
      if (load_main) {o, err_o} <= {dec_o, dec_err};
      else if (shift) {o, err_o} <= {skid_o, skid_err};
      if (load_skid) {skid_o, skid_err} <= {dec_o, dec_err};
    end
`ifdef BSG_DECODE_PIPE_ERR_CNT_EN
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) err_cnt_o <= '0;
    else if (acc & dec_err & ~&err_cnt_o) err_cnt_o <= err_cnt_o + err_cnt_width_lp'(1);
`else
  assign err_cnt_o = '0;
`endif
  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
endmodule

// File: tb/tb_bsg_decode_pipe.sv
// tb_bsg_decode_pipe: directed self-checking bench for bsg_decode_pipe (32-output and 20-output instances)
module tb_bsg_decode_pipe;
  logic clk = 0, rst_n = 1;
  logic v_a = 0, m_a = 0, yen_a = 0, rdy_a, vo_a, err_a, yumi_a;
  logic [4:0] i_a = 0;
  logic [31:0] o_a;
  logic [7:0] cnt_a;
  logic v_b = 0, m_b = 0, yen_b = 1, rdy_b, vo_b, err_b, yumi_b;
  logic [4:0] i_b = 0;
  logic [19:0] o_b;
  logic [7:0] cnt_b;
  int checks = 0, failures = 0;
`ifdef BSG_DECODE_PIPE_ERR_CNT_EN
  localparam bit cnt_en = 1'b1;
`else
  localparam bit cnt_en = 1'b0;
`endif
  always #5 clk = ~clk;
  assign yumi_a = yen_a & vo_a;
  assign yumi_b = yen_b & vo_b;
  bsg_decode_pipe #(.num_out_p(32)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_a), .i(i_a), .mode_i(m_a), .ready_o(rdy_a),
    .v_o(vo_a), .o(o_a), .err_o(err_a), .yumi_i(yumi_a), .err_cnt_o(cnt_a));
  bsg_decode_pipe #(.num_out_p(20)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_b), .i(i_b), .mode_i(m_b), .ready_o(rdy_b),
    .v_o(vo_b), .o(o_b), .err_o(err_b), .yumi_i(yumi_b), .err_cnt_o(cnt_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst_vo", 32'(vo_a), 0);
    chk("rst_ready", 32'(rdy_a), 0);
    chk("rst_o", o_a, 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_cnt", 32'(cnt_b), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("ready_before_edge", 32'(rdy_a), 0);
    tick;
    chk("ready_after_release", 32'(rdy_a), 1);
    chk("vo_after_release", 32'(vo_a), 0);
    yen_a = 1;
    v_a = 1; i_a = 5; m_a = 0;
    tick;
    chk("oh5_vo", 32'(vo_a), 1);
    chk("oh5_o", o_a, 32'h0000_0020);
    chk("oh5_err", 32'(err_a), 0);
    i_a = 5; m_a = 1;
    tick;
    chk("th5_o", o_a, 32'h0000_003F);
    i_a = 31; m_a = 1;
    tick;
    chk("th31_o", o_a, 32'hFFFF_FFFF);
    i_a = 0; m_a = 1;
    tick;
    chk("th0_o", o_a, 32'h0000_0001);
    i_a = 31; m_a = 0;
    tick;
    chk("oh31_o", o_a, 32'h8000_0000);
    v_a = 0;
    tick;
    chk("drain_vo", 32'(vo_a), 0);
    yen_a = 0;
    v_a = 1; i_a = 1; m_a = 0;
    tick;
    chk("bp1_ready", 32'(rdy_a), 1);
    i_a = 2;
    tick;
    chk("bp2_ready", 32'(rdy_a), 0);
    chk("bp2_o", o_a, 32'h2);
    i_a = 3;
    tick;
    chk("bp_hold_o", o_a, 32'h2);
    chk("bp_hold_ready", 32'(rdy_a), 0);
    yen_a = 1;
    tick;
    chk("bp_out2_o", o_a, 32'h4);
    chk("bp_out2_ready", 32'(rdy_a), 1);
    tick;
    chk("bp_out3_o", o_a, 32'h8);
    chk("bp_out3_vo", 32'(vo_a), 1);
    v_a = 0;
    tick;
    chk("bp_drain_vo", 32'(vo_a), 0);
    m_a = 0;
    for (int k = 0; k < 32; k++) begin
      v_a = 1; i_a = 5'(k);
      tick;
      chk("stream_ready", 32'(rdy_a), 1);
      chk("stream_vo", 32'(vo_a), 1);
      chk("stream_o", o_a, 32'h1 << k);
    end
    v_a = 0;
    tick;
    chk("stream_drain_vo", 32'(vo_a), 0);
    v_b = 1; i_b = 25; m_b = 0;
    tick;
    v_b = 0;
    chk("oor_vo", 32'(vo_b), 1);
    chk("oor_o", 32'(o_b), 0);
    chk("oor_err", 32'(err_b), 1);
    chk("oor_cnt1", 32'(cnt_b), cnt_en ? 1 : 0);
    v_b = 1; i_b = 19; m_b = 1;
    tick;
    chk("b_th19_o", 32'(o_b), 32'h000F_FFFF);
    chk("b_th19_err", 32'(err_b), 0);
    i_b = 25; m_b = 1;
    tick;
    chk("oor_th_o", 32'(o_b), 0);
    chk("oor_th_err", 32'(err_b), 1);
    chk("oor_cnt2", 32'(cnt_b), cnt_en ? 2 : 0);
    m_b = 0;
    for (int j = 0; j < 300; j++) begin
      tick;
      if (j == 251) chk("oor_cnt254", 32'(cnt_b), cnt_en ? 254 : 0);
    end
    v_b = 0;
    tick;
    chk("oor_cnt_sat", 32'(cnt_b), cnt_en ? 255 : 0);
    chk("a_cnt_clean", 32'(cnt_a), 0);
    yen_a = 0;
    v_a = 1; i_a = 7;
    tick;
    i_a = 9;
    tick;
    v_a = 0;
    chk("two_ready", 32'(rdy_a), 0);
    chk("two_vo", 32'(vo_a), 1);
    #2 rst_n = 0;
    #1;
    chk("midrst_vo", 32'(vo_a), 0);
    chk("midrst_ready", 32'(rdy_a), 0);
    chk("midrst_o", o_a, 0);
    #2 rst_n = 1;
    yen_a = 1;
    tick;
    chk("post_rst_ready", 32'(rdy_a), 1);
    chk("post_rst_vo", 32'(vo_a), 0);
    tick;
    chk("post_rst_vo2", 32'(vo_a), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
